// File: rtl/mult_result_capture.sv
// Captures the final product of the lockstep 8x8 shift-add multiplier at stage 9 and
// queues it for a valid/ready consumer. Optional running sum: define MULT_CAP_SUM_EN.
module mult_result_capture #(
    parameter int DEPTH  = 4,
    parameter int PHASES = 10
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [15:0]              mult_out,
    output logic [15:0]              res_data,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic                     round_start,
    output logic [3:0]               phase,
    output logic [$clog2(DEPTH):0]   count,
`ifdef MULT_CAP_SUM_EN
    output logic                     overflow,
    output logic [23:0]              sum_out
`else
    output logic                     overflow
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW + 1)'(DEPTH);
    localparam logic [3:0]  LAST_PHASE = 4'(PHASES - 1);

    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          push;
    logic          pop;
    logic          full;
    logic          accept;

    assign push        = (phase == LAST_PHASE);
    assign full        = (count == FULL_COUNT);
    assign res_valid   = (count != '0);
    assign pop         = res_valid && res_ready;
    // A full FIFO still takes the product when the head leaves on the same edge.
    assign accept      = push && (!full || pop);
    assign round_start = (phase == 4'd0);
    assign res_data    = res_valid ? mem[rd_ptr] : 16'h0;

    always_ff @(posedge clk) begin
        if (rst) begin
            phase    <= 4'd0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            phase <= (phase == LAST_PHASE) ? 4'd0 : phase + 4'd1;
            if (accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push && !accept) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && accept) begin
            mem[wr_ptr] <= mult_out;
        end
    end

`ifdef MULT_CAP_SUM_EN
    logic [24:0] sum_next;

    assign sum_next = {1'b0, sum_out} + {9'b0, mult_out};

    // Saturates at the 24-bit ceiling instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_out <= 24'h0;
        end else if (accept) begin
            sum_out <= sum_next[24] ? 24'hFFFFFF : sum_next[23:0];
        end
    end
`endif

endmodule

// File: tb/tb_mult_result_capture.sv
// Scoreboard bench for mult_result_capture: a model queues expected products on each
// phase-9 edge and a negedge monitor compares the DUT head against the queue.
module tb_mult_result_capture;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] mult_out = 16'h0;
    logic [15:0] res_data;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic        round_start;
    logic [3:0]  phase;
    logic [2:0]  count;
    logic        overflow;
`ifdef MULT_CAP_SUM_EN
    logic [23:0] sum_out;
`endif

    int tests = 0;
    int fails = 0;
    bit mon_en = 1'b0;

    logic [15:0] q[$];
    int          tb_phase = 0;
    logic        exp_ovf = 1'b0;
    logic [23:0] exp_sum = 24'h0;

    mult_result_capture #(.DEPTH(DEPTH), .PHASES(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .mult_out   (mult_out),
        .res_data   (res_data),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .round_start(round_start),
        .phase      (phase),
        .count      (count),
`ifdef MULT_CAP_SUM_EN
        .overflow   (overflow),
        .sum_out    (sum_out)
`else
        .overflow   (overflow)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: pop on handshake, push accepted products, saturating sum.
    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                q.delete();
                tb_phase = 0;
                exp_ovf  = 1'b0;
                exp_sum  = 24'h0;
            end else begin
                if (q.size() != 0 && res_ready) begin
                    void'(q.pop_front());
                end
                if (tb_phase == 9) begin
                    if (q.size() < DEPTH) begin
                        q.push_back(mult_out);
                        if (int'(exp_sum) + int'(mult_out) > 24'hFFFFFF) exp_sum = 24'hFFFFFF;
                        else exp_sum = exp_sum + 24'(mult_out);
                    end else begin
                        exp_ovf = 1'b1;
                    end
                end
                tb_phase = (tb_phase == 9) ? 0 : tb_phase + 1;
            end
        end
    end

    // Monitor: head, occupancy and phase checked every cycle against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && !rst) begin
                tests++;
                if (res_valid !== (q.size() != 0) ||
                    res_data !== ((q.size() != 0) ? q[0] : 16'h0)) begin
                    fails++;
                    $display("[TB] FAIL head: valid=%b data=%0d, expected valid=%b data=%0d",
                             res_valid, res_data, (q.size() != 0),
                             (q.size() != 0) ? q[0] : 16'h0);
                end
                tests++;
                if (int'(count) != q.size()) begin
                    fails++;
                    $display("[TB] FAIL count: got %0d, expected %0d", count, q.size());
                end
                tests++;
                if (int'(phase) != tb_phase || round_start !== (tb_phase == 0)) begin
                    fails++;
                    $display("[TB] FAIL phase: got %0d start=%b, expected %0d", phase,
                             round_start, tb_phase);
                end
                tests++;
                if (overflow !== exp_ovf) begin
                    fails++;
                    $display("[TB] FAIL overflow: got %b, expected %b", overflow, exp_ovf);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)",
                     name, act, act, exp, exp);
        end
    endtask

    // One full round; the product appears on mult_out only in the phase-9 cycle.
    task automatic applyStimulus(input logic [15:0] prod, input logic [9:0] ready_mask);
        for (int i = 0; i < 10; i++) begin
            mult_out  = (tb_phase == 9) ? prod : 16'($urandom);
            res_ready = ready_mask[tb_phase];
            tick();
        end
        res_ready = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        doReset();
        mon_en = 1'b1;
        checkOutput("reset phase", phase, 0);
        checkOutput("reset count", count, 0);
        checkOutput("reset valid", res_valid, 0);
        checkOutput("reset data", res_data, 0);
        checkOutput("reset overflow", overflow, 0);
        checkOutput("reset round_start", round_start, 1);

        applyStimulus(16'd143, 10'b0);
        checkOutput("13x11 valid", res_valid, 1);
        checkOutput("13x11 data", res_data, 143);
        checkOutput("13x11 count", count, 1);

        applyStimulus(16'hFE01, 10'b00_0000_0001);
        checkOutput("255x255 data", res_data, 16'hFE01);
        checkOutput("255x255 count", count, 1);
        applyStimulus(16'd1, 10'b0);
        applyStimulus(16'd2, 10'b0);
        checkOutput("hold data stable", res_data, 16'hFE01);
        checkOutput("hold count", count, 3);

        for (int i = 0; i < 5; i++) begin
            mult_out = 16'($urandom);
            tick();
        end
        checkOutput("pre-reset phase", phase, 5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("mid-reset phase", phase, 0);
        checkOutput("mid-reset count", count, 0);
        checkOutput("mid-reset valid", res_valid, 0);
        applyStimulus(16'd63, 10'b0);
        checkOutput("post-reset data", res_data, 63);
        checkOutput("post-reset count", count, 1);

        doReset();
        applyStimulus(16'd323, 10'b0);
        applyStimulus(16'd400, 10'b0);
        applyStimulus(16'd625, 10'b0);
        applyStimulus(16'd16384, 10'b0);
        checkOutput("full count", count, 4);
        checkOutput("full overflow", overflow, 0);
        applyStimulus(16'd9999, 10'b10_0000_0000);
        checkOutput("push+pop count", count, 4);
        checkOutput("push+pop overflow", overflow, 0);
        checkOutput("push+pop head", res_data, 400);
        applyStimulus(16'd3000, 10'b0);
        checkOutput("drop count", count, 4);
        checkOutput("drop overflow", overflow, 1);
        checkOutput("drop head", res_data, 400);
`ifdef MULT_CAP_SUM_EN
        checkOutput("drop sum", sum_out, 323 + 400 + 625 + 16384 + 9999);
`endif
        applyStimulus(16'd50, 10'b11_1111_1111);
        checkOutput("drain count", count, 1);
        checkOutput("drain data", res_data, 50);
        checkOutput("sticky overflow", overflow, 1);
        applyStimulus(16'd77, 10'b11_1111_1111);
        checkOutput("second drain data", res_data, 77);

`ifdef MULT_CAP_SUM_EN
        doReset();
        checkOutput("sum reset", sum_out, 0);
        applyStimulus(16'd143, 10'b11_1111_1111);
        applyStimulus(16'hFE01, 10'b11_1111_1111);
        applyStimulus(16'd1, 10'b11_1111_1111);
        checkOutput("sum 143+65025+1", sum_out, 65169);
        for (int i = 0; i < 258; i++) begin
            applyStimulus(16'hFE01, 10'b11_1111_1111);
        end
        checkOutput("sum saturates", sum_out, 24'hFFFFFF);
        applyStimulus(16'd5, 10'b11_1111_1111);
        checkOutput("sum stays saturated", sum_out, 24'hFFFFFF);
`endif

        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
